// File: rtl/sub_lsu_pkg.sv
// Shared LSU definitions: func3 encodings, store FSM states and the access-size mask.
package sub_lsu_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } st_state_e;

    // Byte mask for the access size; all-zero marks an illegal func3.
    function automatic logic [3:0] size_mask(input logic [2:0] func3);
        case (func3)
            F3_SB:   return 4'b0001;
            F3_SH:   return 4'b0011;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/sub_lsu_store_align.sv
// Combinational store alignment: builds 8-lane byte enables and 64-bit shifted data
// covering the word at the address and the following word.
module sub_lsu_store_align
    import sub_lsu_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    output logic [7:0]  o_be8,
    output logic [63:0] o_d64,
    output logic        o_two_beat,
    output logic        o_illegal
);

    logic [3:0]  w_mask;
    logic [31:0] w_data_m;

    assign w_mask     = size_mask(i_func3);
    assign o_illegal  = (w_mask == 4'b0000);
    assign w_data_m   = i_data & {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    assign o_be8      = {4'b0000, w_mask} << i_off;
    assign o_d64      = {32'd0, w_data_m} << {i_off, 3'b000};
    assign o_two_beat = |o_be8[7:4];

endmodule

// File: rtl/sub_lsu_store.sv
// Store unit: aligns a store, drives one or two req/ack write beats and reports done/err.
// Word-crossing stores are split only when SUB_LSU_STORE_MISALIGN_SPLIT_EN is defined.
module sub_lsu_store
    import sub_lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_func3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    st_state_e   r_state;
    logic        r_done;
    logic        r_err;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_cnt;

    logic [7:0]  w_be8;
    logic [63:0] w_d64;
    logic        w_two_beat;
    logic        w_illegal;
    logic        w_accept;
    logic        w_reject;
    logic        w_more;
    logic        w_timeout;

    sub_lsu_store_align u_align (
        .i_func3    (st_func3),
        .i_off      (st_addr[1:0]),
        .i_data     (st_data),
        .o_be8      (w_be8),
        .o_d64      (w_d64),
        .o_two_beat (w_two_beat),
        .o_illegal  (w_illegal)
    );

`ifdef SUB_LSU_STORE_MISALIGN_SPLIT_EN
    logic        r_two;
    logic [31:0] r_b1_wdata;
    logic [3:0]  r_b1_be;

    assign w_reject = 1'b0;
    assign w_more   = (r_state == ST_BEAT0) && r_two;
`else
    logic w_unused_hi;

    assign w_unused_hi = ^{w_be8[7:4], w_d64[63:32]};
    assign w_reject    = w_two_beat;
    assign w_more      = 1'b0;
`endif

    assign w_accept  = st_valid && st_ready;
    assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == ACK_TIMEOUT - 1);

    // The done cycle keeps ready low even though the FSM is already back in IDLE.
    assign st_ready  = (r_state == ST_IDLE) && !r_done;
    assign st_done   = r_done;
    assign st_err    = r_err;
    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_cnt      <= 32'd0;
`ifdef SUB_LSU_STORE_MISALIGN_SPLIT_EN
            r_two      <= 1'b0;
            r_b1_wdata <= 32'd0;
            r_b1_be    <= 4'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_illegal || w_reject) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_state    <= ST_BEAT0;
                            r_req      <= 1'b1;
                            r_addr     <= {st_addr[31:2], 2'b00};
                            r_be       <= w_be8[3:0];
                            r_wdata    <= w_d64[31:0];
                            r_cnt      <= 32'd0;
`ifdef SUB_LSU_STORE_MISALIGN_SPLIT_EN
                            r_two      <= w_two_beat;
                            r_b1_be    <= w_be8[7:4];
                            r_b1_wdata <= w_d64[63:32];
`endif
                        end
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (mem_ack) begin
                        r_cnt <= 32'd0;
                        if (w_more) begin
`ifdef SUB_LSU_STORE_MISALIGN_SPLIT_EN
                            r_state <= ST_BEAT1;
                            r_addr  <= r_addr + 32'd4;
                            r_be    <= r_b1_be;
                            r_wdata <= r_b1_wdata;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // A first beat already acked stays written; only the error is reported.
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
